// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: write-side fetch sequencer for the pixel async FIFO.
// Bursts frame words from memory into the FIFO and flushes stale data on abort.
module fifo_fill_ctrl #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    BURST_LEN   = 16,
    parameter int                    BURST_W     = 5,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = '0,
    parameter int                    FRAME_WORDS = 153600,
    parameter int                    MAX_OUTST   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic                  fifo_almost_full,
    input  logic                  fifo_full,
    output logic                  fifo_wr_valid,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BURST_W-1:0]    mem_burstcount,
    input  logic                  mem_waitrequest,
    input  logic                  mem_readdatavalid,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    output logic                  frame_done,
    output logic                  overflow_err
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam int SW = OW + BURST_W;
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [WW-1:0] FRAME_LEN = WW'(FRAME_WORDS);
    localparam logic [WW-1:0] BURST_MAX = WW'(BURST_LEN);
    localparam logic [SW-1:0] OUTST_CAP = SW'(MAX_OUTST);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, DONE, FLUSH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WW-1:0]         words_left;
    logic [OW-1:0]         outst;
    logic [OW-1:0]         outst_next;
    logic [BURST_W-1:0]    bc;
    logic                  abort_pend;
    logic                  accept;
    logic                  ret;
    logic                  drop;
    logic                  fits;

    always_comb begin
        bc = BURST_W'(BURST_LEN);
        if (words_left < BURST_MAX) bc = BURST_W'(words_left);
    end

    assign fits   = (SW'(outst) + SW'(bc)) <= OUTST_CAP;
    assign accept = mem_read & ~mem_waitrequest;
    // Returns with nothing outstanding are spurious and never counted.
    assign ret    = mem_readdatavalid & (outst != '0);
    // Words arriving on or after an abort belong to the stale frame.
    assign drop   = (state == FLUSH) | abort_pend
                  | (frame_start & (state != IDLE));

    assign outst_next = outst
                      + (accept ? OW'(mem_burstcount) : '0)
                      - (ret ? OW'(1) : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            addr           <= FRAME_BASE;
            words_left     <= '0;
            outst          <= '0;
            abort_pend     <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_burstcount <= '0;
            fifo_wr_valid  <= 1'b0;
            fifo_wr_data   <= '0;
            frame_done     <= 1'b0;
            overflow_err   <= 1'b0;
        end else begin
            outst         <= outst_next;
            frame_done    <= 1'b0;
            fifo_wr_valid <= ret & ~drop & ~fifo_full;
            if (ret & ~drop) fifo_wr_data <= mem_readdata;
            if (ret & ~drop & fifo_full) overflow_err <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state      <= CHECK;
                        addr       <= FRAME_BASE;
                        words_left <= FRAME_LEN;
                    end
                end
                CHECK: begin
                    if (frame_start) begin
                        if (outst == '0) begin
                            addr       <= FRAME_BASE;
                            words_left <= FRAME_LEN;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (enable && !fifo_almost_full && fits) begin
                        state          <= REQ;
                        mem_read       <= 1'b1;
                        mem_address    <= addr;
                        mem_burstcount <= bc;
                    end
                end
                REQ: begin
                    // An issued request cannot be withdrawn; abort after accept.
                    if (accept) begin
                        mem_read   <= 1'b0;
                        abort_pend <= 1'b0;
                        addr       <= addr
                                    + ADDR_WIDTH'(mem_burstcount) * WORD_BYTES;
                        words_left <= words_left - WW'(mem_burstcount);
                        if (frame_start || abort_pend)
                            state <= FLUSH;
                        else if (words_left == WW'(mem_burstcount))
                            state <= DONE;
                        else
                            state <= CHECK;
                    end else if (frame_start) begin
                        abort_pend <= 1'b1;
                    end
                end
                DONE: begin
                    if (frame_start) begin
                        if (outst == '0) begin
                            state      <= CHECK;
                            addr       <= FRAME_BASE;
                            words_left <= FRAME_LEN;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (outst == '0) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                FLUSH: begin
                    if (outst == '0) begin
                        state      <= CHECK;
                        addr       <= FRAME_BASE;
                        words_left <= FRAME_LEN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed bench for fifo_fill_ctrl: latency-programmable memory model,
// stall, throttle, credit, abort and overflow scenarios.
module tb_fifo_fill_ctrl;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int BW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic          fifo_almost_full = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_valid;
    logic [DW-1:0] fifo_wr_data;
    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_burstcount;
    logic          mem_waitrequest = 1'b0;
    logic          mem_readdatavalid = 1'b0;
    logic [DW-1:0] mem_readdata = '0;
    logic          frame_done;
    logic          overflow_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 3;
    logic [15:0] gen = '0;

    typedef struct {
        logic [AW-1:0] addr;
        int            cnt;
        int            ready;
        logic [15:0]   g;
        int            outst_at;
        int            rets_at;
    } burst_t;

    burst_t        pend[$];
    burst_t        acc[$];
    logic [DW-1:0] wr_log[$];
    int ret_idx = 0;
    int done_cnt = 0;
    int outst = 0;
    int max_outst = 0;
    int rets = 0;
    int drops = 0;

    always #5 clk = ~clk;

    fifo_fill_ctrl #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LEN(16), .BURST_W(5),
        .FRAME_BASE(32'h0), .FRAME_WORDS(40), .MAX_OUTST(32)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .frame_start(frame_start),
        .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
        .fifo_wr_valid(fifo_wr_valid), .fifo_wr_data(fifo_wr_data),
        .mem_read(mem_read), .mem_address(mem_address),
        .mem_burstcount(mem_burstcount),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdatavalid(mem_readdatavalid),
        .mem_readdata(mem_readdata),
        .frame_done(frame_done), .overflow_err(overflow_err)
    );

    function automatic logic [DW-1:0] word(logic [15:0] g, logic [AW-1:0] a);
        return {g, 16'h0, a};
    endfunction

    // Posedge observer: pre-edge DUT outputs, bench-side credit count.
    always @(posedge clk) begin
        burst_t b;
        cyc++;
        if (reset) begin
            pend.delete();
            ret_idx = 0;
            outst = 0;
        end else begin
            if (mem_read && !mem_waitrequest) begin
                b.addr = mem_address;
                b.cnt = int'(mem_burstcount);
                b.ready = cyc + lat;
                b.g = gen;
                b.outst_at = outst;
                b.rets_at = rets;
                pend.push_back(b);
                acc.push_back(b);
                outst += b.cnt;
            end
            if (mem_readdatavalid) begin
                rets++;
                if (outst > 0) outst--;
                if (fifo_full) drops++;
            end
            if (outst > max_outst) max_outst = outst;
            if (fifo_wr_valid) wr_log.push_back(fifo_wr_data);
            if (frame_done) done_cnt++;
        end
    end

    // Memory return path, one word per cycle once a burst's latency expires.
    always @(negedge clk) begin
        mem_readdatavalid = 1'b0;
        if (!reset && pend.size() > 0 && cyc >= pend[0].ready) begin
            mem_readdatavalid = 1'b1;
            mem_readdata = word(pend[0].g, pend[0].addr + AW'(ret_idx * 8));
            ret_idx++;
            if (ret_idx == pend[0].cnt) begin
                ret_idx = 0;
                pend.delete(0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_start = 1'b0;
        enable = 1'b1;
        fifo_almost_full = 1'b0;
        fifo_full = 1'b0;
        mem_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        acc.delete();
        wr_log.delete();
        done_cnt = 0;
        max_outst = 0;
        rets = 0;
        drops = 0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < 1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_acc(input int n);
        int t = 0;
        while (acc.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        int seen = 0;
        do_reset();
        vectors++;
        if ({fifo_wr_valid, mem_read, frame_done, overflow_err} !== 4'b0)
            begin miscompares++;
            $display("FAIL reset_flags: got %b expected 0000",
                {fifo_wr_valid, mem_read, frame_done, overflow_err}); end
        vectors++;
        if (mem_address !== '0 || mem_burstcount !== '0 || fifo_wr_data !== '0)
            begin miscompares++;
            $display("FAIL reset_buses: addr %h bc %0d data %h expected 0",
                mem_address, mem_burstcount, fifo_wr_data); end
        repeat (10) begin
            @(negedge clk);
            if (mem_read) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++;
            $display("FAIL idle_no_req: got %0d request cycles expected 0", seen); end
    endtask

    task automatic test_frame();
        logic [AW-1:0] ea[3] = '{32'd0, 32'd128, 32'd256};
        int ec[3] = '{16, 16, 8};
        int bad = 0;
        do_reset();
        lat = 3;
        gen = 16'h0011;
        pulse_start();
        wait_done();
        vectors++;
        if (done_cnt !== 1) begin miscompares++;
            $display("FAIL frame_done: got %0d expected 1", done_cnt); end
        vectors++;
        if (acc.size() !== 3) begin miscompares++;
            $display("FAIL burst_count: got %0d expected 3", acc.size()); end
        for (int i = 0; i < 3 && i < acc.size(); i++) begin
            vectors++;
            if (acc[i].addr !== ea[i] || acc[i].cnt !== ec[i]) begin
                miscompares++;
                $display("FAIL burst%0d: got (%0d,%0d) expected (%0d,%0d)",
                    i, acc[i].addr, acc[i].cnt, ea[i], ec[i]);
            end
        end
        vectors++;
        if (wr_log.size() !== 40) begin miscompares++;
            $display("FAIL write_count: got %0d expected 40", wr_log.size()); end
        for (int i = 0; i < wr_log.size(); i++)
            if (wr_log[i] !== word(gen, AW'(i * 8))) bad++;
        vectors++;
        if (bad !== 0) begin miscompares++;
            $display("FAIL write_order: got %0d bad words expected 0", bad); end
        repeat (20) @(negedge clk);
        vectors++;
        if (done_cnt !== 1 || mem_read !== 1'b0) begin miscompares++;
            $display("FAIL after_done: done %0d read %b expected 1 0",
                done_cnt, mem_read); end
    endtask

    task automatic test_waitrequest();
        int t = 0;
        do_reset();
        lat = 3;
        gen = 16'h0022;
        pulse_start();
        wait_acc(1);
        mem_waitrequest = 1'b1;
        while (!mem_read && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({mem_read, mem_address, mem_burstcount} !==
                {1'b1, 32'd128, 5'd16}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %b/%0d/%0d expected 1/128/16",
                    i, mem_read, mem_address, mem_burstcount);
            end
            @(negedge clk);
        end
        vectors++;
        if (acc.size() !== 1) begin miscompares++;
            $display("FAIL stall_accepts: got %0d expected 1", acc.size()); end
        mem_waitrequest = 1'b0;
        @(negedge clk);
        vectors++;
        if (acc.size() !== 2 || mem_read !== 1'b0) begin miscompares++;
            $display("FAIL stall_release: accepts %0d read %b expected 2 0",
                acc.size(), mem_read); end
        wait_done();
        vectors++;
        if (acc.size() !== 3 || wr_log.size() !== 40 || done_cnt !== 1)
            begin miscompares++;
            $display("FAIL stall_frame: bursts %0d writes %0d done %0d expected 3 40 1",
                acc.size(), wr_log.size(), done_cnt); end
    endtask

    task automatic test_almost_full();
        int seen = 0;
        int k = 0;
        do_reset();
        lat = 20;
        gen = 16'h0033;
        pulse_start();
        wait_acc(1);
        fifo_almost_full = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (mem_read) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++;
            $display("FAIL af_block: got %0d request cycles expected 0", seen); end
        vectors++;
        if (wr_log.size() !== 16) begin miscompares++;
            $display("FAIL af_inflight: got %0d writes expected 16", wr_log.size()); end
        fifo_almost_full = 1'b0;
        while (!mem_read && k < 2) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'd128) begin miscompares++;
            $display("FAIL af_resume: read %b addr %0d expected 1 128",
                mem_read, mem_address); end
        wait_done();
        vectors++;
        if (wr_log.size() !== 40 || done_cnt !== 1) begin miscompares++;
            $display("FAIL af_frame: writes %0d done %0d expected 40 1",
                wr_log.size(), done_cnt); end
    endtask

    task automatic test_credits();
        do_reset();
        lat = 100;
        gen = 16'h0044;
        pulse_start();
        repeat (60) @(negedge clk);
        vectors++;
        if (acc.size() !== 2 || mem_read !== 1'b0 || outst !== 32)
            begin miscompares++;
            $display("FAIL credit_cap: bursts %0d read %b outst %0d expected 2 0 32",
                acc.size(), mem_read, outst); end
        wait_acc(3);
        vectors++;
        if (acc.size() !== 3) begin miscompares++;
            $display("FAIL credit_third: got %0d bursts expected 3", acc.size()); end
        if (acc.size() >= 3) begin
            vectors++;
            if (acc[2].rets_at < 8 || acc[2].rets_at > 10 ||
                acc[2].addr !== 32'd256 || acc[2].cnt !== 8) begin
                miscompares++;
                $display("FAIL credit_release: rets %0d addr %0d bc %0d expected 8..10 256 8",
                    acc[2].rets_at, acc[2].addr, acc[2].cnt);
            end
        end
        wait_done();
        vectors++;
        if (max_outst !== 32 || wr_log.size() !== 40) begin miscompares++;
            $display("FAIL credit_frame: max outst %0d writes %0d expected 32 40",
                max_outst, wr_log.size()); end
    endtask

    task automatic test_abort();
        int t = 0;
        int old_n = 0;
        int new_n = 0;
        int bad = 0;
        logic [15:0] old_g;
        do_reset();
        lat = 30;
        gen = 16'h0055;
        old_g = gen;
        pulse_start();
        wait_acc(2);
        fifo_almost_full = 1'b1;
        while (outst != 20 && t < 200) begin
            @(negedge clk);
            t++;
        end
        gen = 16'h0056;
        pulse_start();
        t = 0;
        while (outst != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (acc.size() !== 2) begin miscompares++;
            $display("FAIL flush_no_req: got %0d bursts expected 2", acc.size()); end
        fifo_almost_full = 1'b0;
        wait_done();
        foreach (wr_log[i]) begin
            if (wr_log[i][63:48] === old_g) old_n++;
            else begin
                if (wr_log[i] !== word(gen, AW'(new_n * 8))) bad++;
                new_n++;
            end
        end
        vectors++;
        if (old_n !== 12) begin miscompares++;
            $display("FAIL abort_stale: got %0d stale writes expected 12", old_n); end
        vectors++;
        if (new_n !== 40 || bad !== 0) begin miscompares++;
            $display("FAIL abort_refetch: writes %0d bad %0d expected 40 0",
                new_n, bad); end
        vectors++;
        if (done_cnt !== 1) begin miscompares++;
            $display("FAIL abort_done: got %0d expected 1", done_cnt); end
        if (acc.size() >= 3) begin
            vectors++;
            if (acc[2].addr !== 32'd0 || acc[2].outst_at !== 0) begin
                miscompares++;
                $display("FAIL abort_base: addr %0d outst %0d expected 0 0",
                    acc[2].addr, acc[2].outst_at);
            end
        end
    endtask

    task automatic test_overflow();
        int t = 0;
        int seen = 0;
        do_reset();
        lat = 5;
        gen = 16'h0066;
        pulse_start();
        while (wr_log.size() < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        fifo_full = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0;
        wait_done();
        vectors++;
        if (drops !== 1 || wr_log.size() !== 39) begin miscompares++;
            $display("FAIL ovf_drop: drops %0d writes %0d expected 1 39",
                drops, wr_log.size()); end
        vectors++;
        if (overflow_err !== 1'b1 || done_cnt !== 1) begin miscompares++;
            $display("FAIL ovf_flag: err %b done %0d expected 1 1",
                overflow_err, done_cnt); end
        repeat (20) @(negedge clk);
        vectors++;
        if (overflow_err !== 1'b1) begin miscompares++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
        mem_waitrequest = 1'b1;
        pulse_start();
        t = 0;
        while (!mem_read && t < 20) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_read, fifo_wr_valid, frame_done, overflow_err} !== 4'b0 ||
            mem_address !== '0 || mem_burstcount !== '0) begin
            miscompares++;
            $display("FAIL midreset: flags %b addr %0d bc %0d expected 0000 0 0",
                {mem_read, fifo_wr_valid, frame_done, overflow_err},
                mem_address, mem_burstcount);
        end
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_read) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++;
            $display("FAIL midreset_idle: got %0d request cycles expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_waitrequest();
        test_almost_full();
        test_credits();
        test_abort();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
